// File: rtl/turf_kbd_pkg.sv
// Shared scan-code constants, action encoding and key map for the two-player
// PS/2 keyboard command path.
package turf_kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_QUOTE = 8'h52;

  localparam int unsigned N_PLAYERS = 2;
  localparam int unsigned N_ACTIONS = 5;

  typedef enum logic [2:0] {
    ACT_UP    = 3'd0,
    ACT_DOWN  = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_FIRE  = 3'd4
  } action_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] action;
  } key_map_t;

  // Non-extended 75/72/6B/74 are keypad keys and deliberately miss.
  function automatic key_map_t kbd_map(input logic [7:0] code, input logic ext);
    key_map_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     begin m.hit = 1'b1; m.player = 1'b0; m.action = ACT_UP;    end
        SC_S:     begin m.hit = 1'b1; m.player = 1'b0; m.action = ACT_DOWN;  end
        SC_A:     begin m.hit = 1'b1; m.player = 1'b0; m.action = ACT_LEFT;  end
        SC_D:     begin m.hit = 1'b1; m.player = 1'b0; m.action = ACT_RIGHT; end
        SC_SPACE: begin m.hit = 1'b1; m.player = 1'b0; m.action = ACT_FIRE;  end
        SC_QUOTE: begin m.hit = 1'b1; m.player = 1'b1; m.action = ACT_FIRE;  end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_UP:    begin m.hit = 1'b1; m.player = 1'b1; m.action = ACT_UP;    end
        SC_DOWN:  begin m.hit = 1'b1; m.player = 1'b1; m.action = ACT_DOWN;  end
        SC_LEFT:  begin m.hit = 1'b1; m.player = 1'b1; m.action = ACT_LEFT;  end
        SC_RIGHT: begin m.hit = 1'b1; m.player = 1'b1; m.action = ACT_RIGHT; end
        default:  ;
      endcase
    end
    return m;
  endfunction

  function automatic logic [3:0] held_idx(input logic player, input logic [2:0] action);
    return (player ? 4'd5 : 4'd0) + {1'b0, action};
  endfunction

endpackage

// File: rtl/kbd_prefix_decode.sv
// PS/2 prefix (E0/F0) decoder with idle timeout; emits a combinational
// one-cycle {make/break, player, action} event in the RX_VALID cycle.
module kbd_prefix_decode
  import turf_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_err,
  output logic       o_ev_valid,
  output logic       o_ev_make,
  output logic       o_ev_player,
  output logic [2:0] o_ev_action
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);

  prefix_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic          w_done;
  logic          w_ext;
  logic          w_brk;
  key_map_t      w_key;

  always_comb begin
    w_done = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (i_rx_valid && !i_rx_err) begin
      case (r_state)
        IDLE:    w_done = (i_rx_byte != SC_E0) && (i_rx_byte != SC_F0);
        EXT:     begin w_done = (i_rx_byte != SC_F0); w_ext = 1'b1; end
        BRK:     begin w_done = 1'b1; w_brk = 1'b1; end
        EXT_BRK: begin w_done = 1'b1; w_ext = 1'b1; w_brk = 1'b1; end
        default: ;
      endcase
    end
  end

  assign w_key       = kbd_map(i_rx_byte, w_ext);
  assign o_ev_valid  = w_done & w_key.hit;
  assign o_ev_make   = ~w_brk;
  assign o_ev_player = w_key.player;
  assign o_ev_action = w_key.action;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (i_rx_valid) begin
      r_cnt <= '0;
      if (i_rx_err) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_rx_byte == SC_E0)      r_state <= EXT;
            else if (i_rx_byte == SC_F0) r_state <= BRK;
          end
          EXT:     r_state <= (i_rx_byte == SC_F0) ? EXT_BRK : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end else if (r_state != IDLE) begin
      if (r_cnt == CNT_LAST) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kbd_cmd_arbiter.sv
// Two-player keyboard command arbiter: held-key map, per-player pending slot,
// round-robin grant into a valid/ready output register.
// Define KBD_TYPEMATIC_EN to turn repeated makes of a held key into commands.
module kbd_cmd_arbiter
  import turf_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESETN,
  input  logic       RX_VALID,
  input  logic [7:0] RX_BYTE,
  input  logic       RX_ERR,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic       CMD_PLAYER,
  output logic [2:0] CMD_ACTION,
  output logic [9:0] HELD,
  output logic       DROP
);

  logic                  w_ev_valid;
  logic                  w_ev_make;
  logic                  w_ev_player;
  logic [2:0]            w_ev_action;
  logic [3:0]            w_idx;
  logic                  w_new_cmd;
  logic                  w_out_free;
  logic                  w_load;
  logic                  w_grant;

  logic [9:0]            r_held;
  logic [N_PLAYERS-1:0]  r_pend_v;
  logic [1:0][2:0]       r_pend_act;
  logic                  r_cmd_valid;
  logic                  r_cmd_player;
  logic [2:0]            r_cmd_action;
  logic                  r_drop;
  logic                  r_rr_last;

  kbd_prefix_decode #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_dec (
    .i_clk       (CLOCK_50),
    .i_rst_n     (RESETN),
    .i_rx_valid  (RX_VALID),
    .i_rx_byte   (RX_BYTE),
    .i_rx_err    (RX_ERR),
    .o_ev_valid  (w_ev_valid),
    .o_ev_make   (w_ev_make),
    .o_ev_player (w_ev_player),
    .o_ev_action (w_ev_action)
  );

  assign w_idx = held_idx(w_ev_player, w_ev_action);

`ifdef KBD_TYPEMATIC_EN
  assign w_new_cmd = w_ev_valid & w_ev_make;
`else
  logic w_was_held;
  assign w_was_held = r_held[w_idx];
  assign w_new_cmd  = w_ev_valid & w_ev_make & ~w_was_held;
`endif

  // Last-granted player loses only when both slots are occupied.
  assign w_out_free = ~r_cmd_valid | CMD_READY;
  assign w_load     = w_out_free & (|r_pend_v);
  assign w_grant    = (&r_pend_v) ? ~r_rr_last : r_pend_v[1];

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_held       <= '0;
      r_pend_v     <= '0;
      r_pend_act   <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_player <= 1'b0;
      r_cmd_action <= '0;
      r_drop       <= 1'b0;
      r_rr_last    <= 1'b1;
    end else begin
      r_drop <= 1'b0;
      if (w_ev_valid) r_held[w_idx] <= w_ev_make;
      // A slot drained into the output this cycle may be refilled without a drop.
      for (int unsigned p = 0; p < N_PLAYERS; p++) begin
        if (w_new_cmd && (w_ev_player == 1'(p))) begin
          r_pend_v[p]   <= 1'b1;
          r_pend_act[p] <= w_ev_action;
          if (r_pend_v[p] && !(w_load && (w_grant == 1'(p)))) r_drop <= 1'b1;
        end else if (w_load && (w_grant == 1'(p))) begin
          r_pend_v[p] <= 1'b0;
        end
      end
      if (w_out_free) begin
        r_cmd_valid <= |r_pend_v;
        if (w_load) begin
          r_cmd_player <= w_grant;
          r_cmd_action <= r_pend_act[w_grant];
          r_rr_last    <= w_grant;
        end
      end
    end
  end

  assign CMD_VALID  = r_cmd_valid;
  assign CMD_PLAYER = r_cmd_player;
  assign CMD_ACTION = r_cmd_action;
  assign HELD       = r_held;
  assign DROP       = r_drop;

endmodule

// File: doc/kbd_cmd_arbiter.md
KBD_CMD_ARBITER -- requirements
Module: kbd_cmd_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 50000, idle cycles after which a partial prefix sequence is abandoned.
REQ-002 CLOCK_50  in  1  board clock (50 MHz); sole clock, all state on rising edge.
REQ-003 RESETN  in  1  asynchronous, active-low reset.
REQ-004 RX_VALID  in  1  one-cycle pulse: a PS/2 frame byte is available.
REQ-005 RX_BYTE  in  8  received scan-code byte, valid with RX_VALID.
REQ-006 RX_ERR  in  1  frame/parity error flag, valid with RX_VALID.
REQ-007 CMD_VALID  out  1  game command offered.
REQ-008 CMD_READY  in  1  consumer accepts the command.
REQ-009 CMD_PLAYER  out  1  0 = player 0 (WASD/SPACE), 1 = player 1 (arrows/QUOTES).
REQ-010 CMD_ACTION  out  3  0 up, 1 down, 2 left, 3 right, 4 fire.
REQ-011 HELD  out  10  per-key held state; bit = player*5 + action.
REQ-012 DROP  out  1  one-cycle pulse: a pending command was overwritten.

Function
REQ-013 Prefix FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-014 IDLE: E0 -> EXT, F0 -> BRK, other byte -> make event (non-extended), stay IDLE.
REQ-015 EXT: F0 -> EXT_BRK, other byte -> make event (extended) -> IDLE; BRK -> break event (non-ext) -> IDLE; EXT_BRK -> break event (ext) -> IDLE.
REQ-016 RX_VALID with RX_ERR=1 SHALL discard the byte and force IDLE from any state.
REQ-017 In EXT/BRK/EXT_BRK, TIMEOUT_CYC consecutive cycles without RX_VALID SHALL force IDLE; counter clears on every RX_VALID.
REQ-018 Map: non-ext 1D/1B/1C/23/29 -> P0 up/down/left/right/fire; ext 75/72/6B/74 -> P1 up/down/left/right; non-ext 52 -> P1 fire; all else ignored (non-ext 75 etc. are keypad, ignored).
REQ-019 Mapped make SHALL set its HELD bit the cycle after RX_VALID; mapped break SHALL clear it; breaks never generate commands.
REQ-020 Mapped make with HELD bit previously 0 SHALL load the player's one-entry pending slot the cycle after RX_VALID.
REQ-021 Make into an occupied pending slot SHALL overwrite it (latest wins) and pulse DROP.
REQ-022 Output register SHALL load from pending when empty or transferring (CMD_VALID & CMD_READY); CMD_VALID rises 2 cycles after the RX_VALID of the make.
REQ-023 Both slots pending: round-robin; last-granted player loses; pointer flips on each load.
REQ-024 CMD_VALID SHALL stay high with CMD_PLAYER/CMD_ACTION stable until CMD_READY; no retraction.
REQ-025 Back-to-back transfer SHALL be supported: new command may load the same cycle a transfer completes.

Reset
REQ-026 RESETN low: FSM IDLE, timeout counter 0, HELD 0, pending slots empty, CMD_VALID 0, CMD_PLAYER 0, CMD_ACTION 0, DROP 0, RR pointer favours player 0.
REQ-027 Reset mid-sequence or mid-handshake SHALL abandon all state immediately; the first byte after release is decoded from IDLE.

Configuration
REQ-028 Macro KBD_TYPEMATIC_EN defined: make of an already-held key (typematic repeat) SHALL also load a command per REQ-020/021.
REQ-029 Macro undefined: repeated makes of a held key SHALL only refresh nothing and generate no command.

Structure
REQ-030 Package turf_kbd_pkg SHALL hold scan-code constants (E0, F0, key codes), action encoding, player count, prefix-state typedef.
REQ-031 Sub-module kbd_prefix_decode SHALL contain the prefix FSM, timeout counter and key map, emitting one-cycle {make/break, player, action} events; top holds HELD, pending slots, arbiter, output register.

Verification
REQ-032 Bytes 1D then F0 1D, CMD_READY=1 -> one command P0/up 2 cycles after first RX_VALID; HELD[0] set then cleared.
REQ-033 Bytes E0 74 with CMD_READY=0 for 10 cycles -> CMD_VALID held, P1/right stable, taken on READY.
REQ-034 Makes 1C (P0 left) and 52 (P1 fire) while READY=0, then READY=1 -> P0 then P1 granted; repeat in reverse order grants other-first per RR.
REQ-035 E0 then silence TIMEOUT_CYC cycles then 75 -> ignored (keypad), no command; RX_ERR during BRK -> IDLE, next 23 yields P0/right.
REQ-036 1D sent three times without break: 1 command (macro undefined) or 3 commands with DROP pulses when READY=0 (KBD_TYPEMATIC_EN).
REQ-037 RESETN asserted while CMD_VALID=1 -> all outputs 0 asynchronously; next 29 after release -> P0/fire.
